// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes and default latencies.
package md_unit_pkg;

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic for the MD unit: signed/unsigned multiply and divide,
// including the divide-by-zero result rule.
module md_calc
   import md_unit_pkg::*;
(
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo
);

   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic               div_zero;
   logic               div_ovf;
   logic [31:0]        div_b;
   logic signed [31:0] quot_s;
   logic signed [31:0] rem_s;
   logic [31:0]        quot_u;
   logic [31:0]        rem_u;

   assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
   assign prod_u = {32'b0, A} * {32'b0, B};

   // Substituting 1 for the divisor keeps the dividers well defined for B==0
   // and for 0x80000000 / -1, which then yields quotient A, remainder 0.
   assign div_zero = (B == 32'd0);
   assign div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF) && (md_op == MD_DIV);
   assign div_b    = (div_zero || div_ovf) ? 32'd1 : B;

   assign quot_s = $signed(A) / $signed(div_b);
   assign rem_s  = $signed(A) % $signed(div_b);
   assign quot_u = A / div_b;
   assign rem_u  = A % div_b;

   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      case (md_op)
         MD_MULT: begin
            res_hi = prod_s[63:32];
            res_lo = prod_s[31:0];
         end
         MD_MULTU: begin
            res_hi = prod_u[63:32];
            res_lo = prod_u[31:0];
         end
         MD_DIV, MD_DIVU: begin
            if (div_zero) begin
               res_hi = A;
               res_lo = 32'hFFFF_FFFF;
            end else if (md_op == MD_DIV) begin
               res_hi = rem_s;
               res_lo = quot_s;
            end else begin
               res_hi = rem_u;
               res_lo = quot_u;
            end
         end
         default: begin
            res_hi = 32'd0;
            res_lo = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide controller: owns HI/LO, sequences latency with a
// down-counter and requests a D-stage stall while the unit is occupied.
//
//   state | meaning
//   IDLE  | count == 0, may launch or execute mthi/mtlo
//   RUN   | count != 0, result held in temp regs until count reaches 1
module md_unit
   import md_unit_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int CW = $clog2(max_int(MULT_CYCLES, DIV_CYCLES)) + 1;

   logic [CW-1:0] count;
   logic [31:0]   temp_hi;
   logic [31:0]   temp_lo;
   logic [31:0]   res_hi;
   logic [31:0]   res_lo;

   md_calc u_calc (
      .md_op  (md_op),
      .A      (A),
      .B      (B),
      .res_hi (res_hi),
      .res_lo (res_lo)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         temp_hi <= 32'd0;
         temp_lo <= 32'd0;
         HI      <= 32'd0;
         LO      <= 32'd0;
      end else if (count != '0) begin
         count <= count - 1'b1;
         if (count == CW'(1)) begin
            HI <= temp_hi;
            LO <= temp_lo;
         end
      end else if (start) begin
         case (md_op)
            MD_MULT, MD_MULTU: begin
               temp_hi <= res_hi;
               temp_lo <= res_lo;
               count   <= CW'(MULT_CYCLES);
            end
            MD_DIV, MD_DIVU: begin
               temp_hi <= res_hi;
               temp_lo <= res_lo;
               count   <= CW'(DIV_CYCLES);
            end
            MD_MTHI: HI <= A;
            MD_MTLO: LO <= A;
            default: ;
         endcase
      end
   end

   assign busy     = (count != '0);
   assign stall_md = md_use_D && (start || busy);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: timestamp-based reference model, per-cycle
// compare, directed literal checks and randomized operation traffic.
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] A;
   logic [31:0] B;
   logic        md_use_D;
   logic        busy;
   logic        stall_md;
   logic [31:0] HI;
   logic [31:0] LO;

   int vectors     = 0;
   int miscompares = 0;
   int violations  = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .md_op    (md_op),
      .A        (A),
      .B        (B),
      .md_use_D (md_use_D),
      .busy     (busy),
      .stall_md (stall_md),
      .HI       (HI),
      .LO       (LO)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a launch schedules its result for a future cycle number.
   int          cyc;
   int          done_cyc;
   logic [31:0] m_hi, m_lo, p_hi, p_lo;

   task automatic model_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] hi, output logic [31:0] lo);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, up;
      logic [63:0]     prod;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      hi = 32'd0;
      lo = 32'd0;
      if (op == 3'd0) begin
         prod = sa * sb;
         hi = prod[63:32];
         lo = prod[31:0];
      end else if (op == 3'd1) begin
         up = ua * ub;
         hi = up[63:32];
         lo = up[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else if (op == 3'd2) begin
         sq = sa / sb;
         sr = sa - sq * sb;
         hi = sr[31:0];
         lo = sq[31:0];
      end else begin
         hi = 32'(ua % ub);
         lo = 32'(ua / ub);
      end
   endtask

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc      = 0;
         done_cyc = 0;
         m_hi     = 32'd0;
         m_lo     = 32'd0;
      end else if (cyc < done_cyc) begin
         if (start) violations++;
         cyc++;
         if (cyc == done_cyc) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else begin
         cyc++;
         if (start) begin
            if (md_op <= 3'd3) begin
               model_calc(md_op, A, B, p_hi, p_lo);
               done_cyc = cyc + ((md_op <= 3'd1) ? 5 : 10);
            end else if (md_op == 3'd4) begin
               m_hi = A;
            end else if (md_op == 3'd5) begin
               m_lo = A;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("busy", {31'b0, busy}, {31'b0, cyc < done_cyc});
         chk("stall_md", {31'b0, stall_md}, {31'b0, md_use_D && (start || cyc < done_cyc)});
         chk("HI", HI, m_hi);
         chk("LO", LO, m_lo);
      end
   end

   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic use_d);
      @(posedge clk); #1;
      start = 1'b1; md_op = op; A = a; B = b; md_use_D = use_d;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Counts busy cycles seen at negedges; returns at the first idle negedge.
   task automatic wait_done(input bit wiggle, output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (wiggle) begin
            A = $urandom;
            B = $urandom;
         end
         if (n > 40) begin
            chk("busy_timeout", 32'(n), 32'd0);
            break;
         end
      end
   endtask

   int n;

   initial begin
      reset = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0; md_use_D = 1'b0;
      #12;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_HI", HI, 32'd0);
      chk("reset_LO", LO, 32'd0);
      #10 reset = 1'b0;

      launch(3'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
      wait_done(1'b0, n);
      chk("mult_cycles", 32'(n), 32'd5);
      chk("mult_HI", HI, 32'hFFFF_FFFF);
      chk("mult_LO", LO, 32'hFFFF_FFF1);
      md_use_D = 1'b0;

      launch(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
      wait_done(1'b0, n);
      chk("multu_cycles", 32'(n), 32'd5);
      chk("multu_HI", HI, 32'd1);
      chk("multu_LO", LO, 32'hFFFF_FFFE);

      launch(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
      wait_done(1'b1, n);
      chk("div_cycles", 32'(n), 32'd10);
      chk("div_HI", HI, 32'hFFFF_FFFF);
      chk("div_LO", LO, 32'hFFFF_FFFD);

      launch(3'd3, 32'd7, 32'd2, 1'b0);
      wait_done(1'b1, n);
      chk("divu_HI", HI, 32'd1);
      chk("divu_LO", LO, 32'd3);

      launch(3'd2, 32'h1234_5678, 32'd0, 1'b0);
      wait_done(1'b0, n);
      chk("div0_cycles", 32'(n), 32'd10);
      chk("div0_HI", HI, 32'h1234_5678);
      chk("div0_LO", LO, 32'hFFFF_FFFF);

      @(posedge clk); #1;
      start = 1'b1; md_op = 3'd4; A = 32'hAA;
      @(posedge clk); #1;
      md_op = 3'd5; A = 32'h55;
      chk("mthi_HI", HI, 32'hAA);
      chk("mthi_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      chk("mtlo_LO", LO, 32'h55);
      chk("mtlo_HI", HI, 32'hAA);

      launch(3'd0, 32'd3, 32'd4, 1'b0);
      start = 1'b1; md_op = 3'd1; A = 32'd100; B = 32'd100;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0, n);
      chk("ignored_cycles", 32'(n), 32'd4);
      chk("ignored_HI", HI, 32'd0);
      chk("ignored_LO", LO, 32'd12);

      launch(3'd3, 32'd7, 32'd2, 1'b0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("areset_busy", {31'b0, busy}, 32'd0);
      chk("areset_HI", HI, 32'd0);
      chk("areset_LO", LO, 32'd0);
      @(negedge clk); #2 reset = 1'b0;
      launch(3'd0, 32'd6, 32'd7, 1'b1);
      wait_done(1'b0, n);
      chk("post_reset_cycles", 32'(n), 32'd5);
      chk("post_reset_LO", LO, 32'd42);
      chk("post_reset_HI", HI, 32'd0);

      for (int i = 0; i < 1500; i++) begin
         @(posedge clk); #1;
         start    = ($urandom_range(0, 3) == 0);
         md_op    = 3'($urandom_range(0, 7));
         A        = $urandom;
         B        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         md_use_D = $urandom_range(0, 1) == 1;
         if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) B = 32'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(1'b0, n);
      @(negedge clk);

      $display("start-while-busy events ignored: %0d", violations);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
